hyper_req_queue: RTL and testbench

- Command front-end that sits directly upstream of hyper_xface.
- Accepts read/write commands from the local bus over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command to hyper_xface as a single-cycle rd_req/wr_req pulse, then tracks hyper_xface busy to completion.
- Returns read data to the requester on a held valid/ready response channel.

---
 rtl/hyper_pkg.sv | 34 +++
 rtl/hyper_cmd_fifo.sv | 51 +++++
 rtl/hyper_req_queue.sv | 151 +++++++++++++++
 tb/tb_hyper_req_queue.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_pkg.sv
// Shared definitions for the hyper_xface command front-end.
package hyper_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Packed command word: wr + reg + addr + wd + be
  localparam int unsigned CMD_W  = 70;

  // Field offsets inside the packed command word (LSB first)
  localparam int unsigned BE_LSB   = 0;
  localparam int unsigned WD_LSB   = BE_LSB + BE_W;
  localparam int unsigned ADDR_LSB = WD_LSB + DATA_W;
  localparam int unsigned REG_BIT  = ADDR_LSB + ADDR_W;
  localparam int unsigned WR_BIT   = REG_BIT + 1;

  typedef struct packed {
    logic              wr;
    logic              reg_sp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [BE_W-1:0]   be;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_END   = 3'd3,
    ST_RSP        = 3'd4
  } state_t;

endpackage

// File: rtl/hyper_cmd_fifo.sv
// Synchronous command FIFO; push and pop may coincide when full.
module hyper_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 70
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hyper_req_queue.sv
// Buffers local-bus commands and replays them one at a time to hyper_xface.
module hyper_req_queue
  import hyper_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned START_TMO = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic        cmd_reg,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wd,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_d,
  output logic        rsp_err,
  output logic        rd_req,
  output logic        wr_req,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  output logic [3:0]  wr_byte_en,
  output logic        mem_or_reg,
  input  logic        busy,
  input  logic        rd_rdy,
  input  logic [31:0] rd_d,
  output logic        idle
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned TMO_W = (START_TMO < 1) ? 1 : $clog2(START_TMO + 1);

  state_t             state;
  logic [TMO_W-1:0]   tmo;
  logic               cur_wr;
  logic               got_rd;
  cmd_t               cmd_in;
  logic [CMD_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push_c;
  logic               pop_c;

  assign cmd_in = '{wr: cmd_wr, reg_sp: cmd_reg, addr: cmd_addr, wd: cmd_wd, be: cmd_be};
  assign cmd_ready = !fifo_full;
  assign push_c    = cmd_valid && cmd_ready;
  assign pop_c     = (state == ST_IDLE) && !fifo_empty && !rsp_valid && !busy;
  assign idle      = (fifo_count == '0) && (state == ST_IDLE);

  hyper_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (cmd_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Command sequencer: pop, pulse, wait for busy start/end, return read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      tmo        <= '0;
      cur_wr     <= 1'b0;
      got_rd     <= 1'b0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      addr       <= '0;
      wr_d       <= '0;
      wr_byte_en <= '0;
      mem_or_reg <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_d      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop_c) begin
            addr       <= head[ADDR_LSB +: ADDR_W];
            wr_d       <= head[WD_LSB +: DATA_W];
            wr_byte_en <= head[BE_LSB +: BE_W];
            mem_or_reg <= head[REG_BIT];
            cur_wr     <= head[WR_BIT];
            wr_req     <= head[WR_BIT];
            rd_req     <= !head[WR_BIT];
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rd_req  <= 1'b0;
          wr_req  <= 1'b0;
          tmo     <= TMO_W'(START_TMO);
          got_rd  <= 1'b0;
          rsp_d   <= '0;
          rsp_err <= 1'b0;
          state   <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (busy) begin
            state <= ST_WAIT_END;
          end else if (tmo == '0) begin
            // busy never rose: writes are dropped, reads report an error
            if (cur_wr) begin
              state <= ST_IDLE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_d     <= '0;
              state     <= ST_RSP;
            end
          end else begin
            tmo <= tmo - 1'b1;
          end
        end
        ST_WAIT_END: begin
          if (rd_rdy && !cur_wr) begin
            rsp_d  <= rd_d;
            got_rd <= 1'b1;
          end
          if (!busy) begin
            if (cur_wr) begin
              state <= ST_IDLE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= !(got_rd || rd_rdy);
              state     <= ST_RSP;
            end
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_req_queue.sv
// Scoreboard bench for hyper_req_queue with a behavioural hyper_xface model.
module tb_hyper_req_queue;

  localparam logic [31:0] RD_KEY = 32'hCAFEF02D;

  typedef struct packed {
    logic        wr;
    logic        rg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
  } req_t;

  typedef struct packed {
    logic [31:0] d;
    logic        err;
    logic        chk_d;
  } rsp_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic        cmd_reg;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wd;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_d;
  logic        rsp_err;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_d;
  logic [3:0]  wr_byte_en;
  logic        mem_or_reg;
  logic        busy;
  logic        rd_rdy;
  logic [31:0] rd_d;
  logic        idle;

  logic        busy_m;
  logic        force_busy;
  logic        model_en;
  logic        model_no_rdrdy;
  int          model_len;

  int checks;
  int failures;
  int cyc;
  int pulse_cnt;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  assign busy = busy_m | force_busy;

  hyper_req_queue #(.DEPTH(4), .START_TMO(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_reg    (cmd_reg),
    .cmd_addr   (cmd_addr),
    .cmd_wd     (cmd_wd),
    .cmd_be     (cmd_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_d      (rsp_d),
    .rsp_err    (rsp_err),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .addr       (addr),
    .wr_d       (wr_d),
    .wr_byte_en (wr_byte_en),
    .mem_or_reg (mem_or_reg),
    .busy       (busy),
    .rd_rdy     (rd_rdy),
    .rd_d       (rd_d),
    .idle       (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // hyper_xface model: busy one cycle after a pulse, held model_len cycles
  initial begin : xface_model
    logic is_rd;
    busy_m = 1'b0;
    rd_rdy = 1'b0;
    rd_d   = '0;
    forever begin
      @(negedge clk);
      if ((rd_req || wr_req) && model_en && !reset) begin
        is_rd = rd_req;
        @(posedge clk); #1;
        busy_m = 1'b1;
        for (int k = 1; k < model_len; k++) begin
          @(posedge clk); #1;
        end
        if (is_rd && !model_no_rdrdy) begin
          rd_rdy = 1'b1;
          rd_d   = addr ^ RD_KEY;
        end
        @(posedge clk); #1;
        busy_m = 1'b0;
        rd_rdy = 1'b0;
        rd_d   = '0;
      end
    end
  end

  // Monitor: pops expectations on request pulses and response handshakes
  initial begin : monitor
    req_t        e;
    rsp_t        s;
    logic        hold;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_be;
    logic        s_reg;
    logic        prev_rv, prev_rr, prev_e;
    logic [31:0] prev_d;
    hold = 1'b0;
    prev_rv = 1'b0; prev_rr = 1'b0; prev_e = 1'b0; prev_d = '0;
    s_addr = '0; s_wd = '0; s_be = '0; s_reg = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold    = 1'b0;
        prev_rv = 1'b0;
      end else begin
        if (rd_req || wr_req) begin
          pulse_cnt++;
          check("req_exclusive", 32'(rd_req && wr_req), 32'd0);
          s_addr = addr; s_wd = wr_d; s_be = wr_byte_en; s_reg = mem_or_reg;
          hold = 1'b1;
          if (exp_req.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: got wr_req=%0b rd_req=%0b addr=0x%08h expected none", wr_req, rd_req, addr);
          end else begin
            e = exp_req.pop_front();
            check("req_is_write", 32'(wr_req), 32'(e.wr));
            check("req_addr", addr, e.a);
            check("req_mem_or_reg", 32'(mem_or_reg), 32'(e.rg));
            if (e.wr) begin
              check("req_wr_d", wr_d, e.wd);
              check("req_byte_en", 32'(wr_byte_en), 32'(e.be));
            end
          end
        end else if (hold) begin
          checks++;
          if ({addr, wr_d, wr_byte_en, mem_or_reg} !== {s_addr, s_wd, s_be, s_reg}) begin
            failures++;
            $display("FAIL req_hold: got addr=0x%08h wd=0x%08h be=%h reg=%0b expected addr=0x%08h wd=0x%08h be=%h reg=%0b",
                     addr, wr_d, wr_byte_en, mem_or_reg, s_addr, s_wd, s_be, s_reg);
          end
        end
        if (rsp_valid && !prev_rv && exp_rsp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rsp_d=0x%08h expected no response", rsp_d);
        end
        if (rsp_valid && prev_rv && !prev_rr) begin
          checks++;
          if ({rsp_d, rsp_err} !== {prev_d, prev_e}) begin
            failures++;
            $display("FAIL rsp_hold: got d=0x%08h err=%0b expected d=0x%08h err=%0b", rsp_d, rsp_err, prev_d, prev_e);
          end
        end
        if (rsp_valid && rsp_ready && exp_rsp.size() != 0) begin
          s = exp_rsp.pop_front();
          check("rsp_err", 32'(rsp_err), 32'(s.err));
          if (s.chk_d) check("rsp_d", rsp_d, s.d);
        end
        prev_rv = rsp_valid;
        prev_rr = rsp_ready;
        prev_d  = rsp_d;
        prev_e  = rsp_err;
      end
    end
  end

  // Offer one command; expectations are queued once it is accepted
  task automatic push_cmd(input logic wr, input logic rg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] exp_d, input logic exp_err, input logic chk_d);
    int   n;
    logic ok;
    req_t r;
    rsp_t s;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_wr = wr; cmd_reg = rg; cmd_addr = a; cmd_wd = wd; cmd_be = be;
    n = 0;
    forever begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      if (ok) begin
        r = '{wr: wr, rg: rg, a: a, wd: wd, be: be};
        exp_req.push_back(r);
        if (!wr) begin
          s = '{d: exp_d, err: exp_err, chk_d: chk_d};
          exp_rsp.push_back(s);
        end
        break;
      end
      n++;
      if (n >= 64) begin
        checks++;
        failures++;
        $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, addr=0x%08h", n, a);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // Bounded wait at negedges: 0=rsp_valid, 1=fully idle, 2=busy
  task automatic wait_cond(input int which, input int budget, input string name);
    int   n;
    logic hit;
    n = 0;
    forever begin
      @(negedge clk);
      case (which)
        0:       hit = rsp_valid;
        1:       hit = idle && !busy && !rsp_valid;
        default: hit = busy;
      endcase
      if (hit) break;
      n++;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL %s: got timeout after %0d cycles expected condition", name, budget);
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"},  32'(cmd_ready), 32'd1);
    check({tag, "_idle"},       32'(idle), 32'd1);
    check({tag, "_rd_req"},     32'(rd_req), 32'd0);
    check({tag, "_wr_req"},     32'(wr_req), 32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"},    32'(rsp_err), 32'd0);
    check({tag, "_rsp_d"},      rsp_d, 32'd0);
    check({tag, "_addr"},       addr, 32'd0);
    check({tag, "_wr_d"},       wr_d, 32'd0);
    check({tag, "_byte_en"},    32'(wr_byte_en), 32'd0);
    check({tag, "_mem_or_reg"}, 32'(mem_or_reg), 32'd0);
  endtask

  initial begin : stimulus
    int c0;
    int pc0;
    checks = 0; failures = 0; pulse_cnt = 0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_reg = 1'b0;
    cmd_addr = '0; cmd_wd = '0; cmd_be = '0;
    rsp_ready = 1'b0;
    force_busy = 1'b0; model_en = 1'b1; model_no_rdrdy = 1'b0; model_len = 8;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single write: pulse two cycles after the push cycle, no response
    push_cmd(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk); check("wr_pulse_early", 32'(wr_req), 32'd0);
    @(negedge clk); check("wr_pulse", 32'(wr_req), 32'd1);
    check("wr_no_rd", 32'(rd_req), 32'd0);
    @(negedge clk); check("wr_pulse_single", 32'(wr_req), 32'd0);
    wait_cond(1, 100, "write_done");
    check("write_no_rsp", 32'(rsp_valid), 32'd0);

    // Single read with response backpressure for 5 cycles
    push_cmd(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_cond(0, 100, "read_rsp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("read_rsp_held", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk); check("read_rsp_cleared", 32'(rsp_valid), 32'd0);
    wait_cond(1, 100, "read_done");

    // Fill the FIFO while busy is forced, then drain in order W,R,W,W,R
    rsp_ready = 1'b1;
    force_busy = 1'b1;
    push_cmd(1'b1, 1'b0, 32'h100, 32'h11111111, 4'h3, 32'h0, 1'b0, 1'b0);
    push_cmd(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 32'hCAFEF129, 1'b0, 1'b1);
    push_cmd(1'b1, 1'b1, 32'h108, 32'h22222222, 4'hC, 32'h0, 1'b0, 1'b0);
    push_cmd(1'b1, 1'b0, 32'h10C, 32'h33333333, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
    check("fill_not_idle", 32'(idle), 32'd0);
    check("fill_no_issue", 32'(pulse_cnt), 32'd2);
    fork
      push_cmd(1'b0, 1'b1, 32'h110, 32'h0, 4'h0, 32'hCAFEF13D, 1'b0, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1 force_busy = 1'b0;
      end
    join
    wait_cond(1, 300, "fill_drain");
    check("fill_pulses", 32'(pulse_cnt), 32'd7);

    // Start timeout on a read, then a write that is silently dropped
    rsp_ready = 1'b0;
    model_en = 1'b0;
    push_cmd(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk); check("tmo_rd_pulse", 32'(rd_req), 32'd1);
    c0 = cyc;
    push_cmd(1'b1, 1'b0, 32'h204, 32'h44444444, 4'h5, 32'h0, 1'b0, 1'b0);
    wait_cond(0, 40, "tmo_rsp");
    check("tmo_rsp_latency", 32'(cyc - c0), 32'd17);
    pc0 = pulse_cnt;
    repeat (10) @(negedge clk);
    check("tmo_next_blocked", 32'(pulse_cnt), 32'(pc0));
    @(posedge clk); #1; rsp_ready = 1'b1;
    wait_cond(1, 80, "tmo_write_drop");
    check("tmo_write_issued", 32'(pulse_cnt), 32'(pc0 + 1));
    model_en = 1'b1;

    // Two reads with the response held off: second waits for the handshake
    rsp_ready = 1'b0;
    push_cmd(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 32'hCAFEF32D, 1'b0, 1'b1);
    push_cmd(1'b0, 1'b0, 32'h304, 32'h0, 4'h0, 32'hCAFEF329, 1'b0, 1'b1);
    wait_cond(0, 100, "bp_rsp1");
    pc0 = pulse_cnt;
    repeat (20) @(negedge clk);
    check("bp_second_blocked", 32'(pulse_cnt), 32'(pc0));
    @(posedge clk); #1; rsp_ready = 1'b1;
    wait_cond(1, 100, "bp_done");
    check("bp_second_issued", 32'(pulse_cnt), 32'(pc0 + 1));

    // Read that ends without an rd_rdy pulse reports an error
    model_no_rdrdy = 1'b1;
    push_cmd(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    wait_cond(1, 100, "nordy_done");
    model_no_rdrdy = 1'b0;

    // Reset during WAIT_END with two commands still queued
    model_len = 30;
    push_cmd(1'b1, 1'b0, 32'h500, 32'h55555555, 4'hF, 32'h0, 1'b0, 1'b0);
    push_cmd(1'b0, 1'b0, 32'h504, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    push_cmd(1'b0, 1'b1, 32'h508, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    wait_cond(2, 20, "rst_busy");
    check("rst_queued", 32'(cmd_ready && !idle), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_req.delete();
    exp_rsp.delete();
    pc0 = pulse_cnt;
    #1;
    check_reset_values("midrst");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_pulses", 32'(pulse_cnt), 32'(pc0));
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    model_len = 8;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
